// File: rtl/rcc_pkg.sv
// Shared types and constants for the reset/clock controller sequencer.
package rcc_pkg;

   typedef enum logic [2:0] {
      ST_LS_RUN  = 3'd0,
      ST_HS_OSC  = 3'd1,
      ST_SW_GATE = 3'd2,
      ST_SW_SEL  = 3'd3,
      ST_HS_RUN  = 3'd4,
      ST_SLEEP   = 3'd5
   } rcc_state_e;

   localparam logic [1:0] MODE_LS    = 2'b00;
   localparam logic [1:0] MODE_HS    = 2'b01;
   localparam logic [1:0] MODE_SLEEP = 2'b10;
   localparam logic [1:0] MODE_TRANS = 2'b11;

   localparam int OSC_WAIT_DEF = 64;
   localparam int OSC_TMO_DEF  = 1024;
   localparam int SW_WAIT_DEF  = 4;

   // Externally visible mode for a given sequencer state.
   function automatic logic [1:0] state_mode(input rcc_state_e s);
      logic [1:0] m;
      case (s)
         ST_LS_RUN: m = MODE_LS;
         ST_HS_RUN: m = MODE_HS;
         ST_SLEEP:  m = MODE_SLEEP;
         default:   m = MODE_TRANS;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/rcc_seq_if.sv
// Request/status bundle between the power/clock requester and the sequencer.
interface rcc_seq_if;

   logic       hs_req;
   logic       sleep_req;
   logic       wake;
   logic       hosc_rdy;
   logic       hosc_en;
   logic       clk_sel;
   logic       run_ctrl;
   logic [1:0] mode;
   logic       busy;
   logic       sw_done;
   logic       osc_err;

   modport master (
      output hs_req, sleep_req, wake, hosc_rdy,
      input  hosc_en, clk_sel, run_ctrl, mode, busy, sw_done, osc_err
   );

   modport slave (
      input  hs_req, sleep_req, wake, hosc_rdy,
      output hosc_en, clk_sel, run_ctrl, mode, busy, sw_done, osc_err
   );

endinterface

// File: rtl/rcc_dly_cnt.sv
// Clear-on-load saturating delay counter with a terminal-count compare.
module rcc_dly_cnt #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic [W-1:0] term,
   output logic [W-1:0] cnt,
   output logic         hit
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Restart on load, otherwise count up and stick at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (cnt_q != {W{1'b1}}) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign hit = (cnt_q == term);

endmodule

// File: rtl/rcc_seq.sv
// Clock-mode sequencer: oscillator start, gated lclk/hclk switch and sleep/wake,
// running entirely on the always-on lclk.
module rcc_seq
   import rcc_pkg::*;
#(
   parameter int OSC_WAIT = OSC_WAIT_DEF,
   parameter int OSC_TMO  = OSC_TMO_DEF,
   parameter int SW_WAIT  = SW_WAIT_DEF
) (
   input  logic      lclk,
   input  logic      rst,
   rcc_seq_if.slave  bus
);

   localparam int CNT_W = $clog2(OSC_TMO + 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(OSC_WAIT - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(OSC_TMO - 1);
   localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_WAIT - 1);

   rcc_state_e state_q, state_d;
   logic       dir_hs_q, dir_hs_d;
   logic       sleep_pend_q, sleep_pend_d;
   logic       hs_block_q, hs_block_d;
   logic       hosc_en_q, hosc_en_d;
   logic       clk_sel_q, clk_sel_d;
   logic       run_ctrl_q, run_ctrl_d;
   logic [1:0] mode_q, mode_d;
   logic       busy_q, busy_d;
   logic       sw_done_q, sw_done_d;
   logic       osc_err_q, osc_err_d;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_term;
   logic             cnt_hit;
   logic             cnt_clr;
   logic             sleep_now;

   assign sleep_now = bus.sleep_req | sleep_pend_q;
   assign cnt_clr   = (state_d != state_q);

   rcc_dly_cnt #(.W(CNT_W)) u_dly (
      .clk  (lclk),
      .rst  (rst),
      .clr  (cnt_clr),
      .term (cnt_term),
      .cnt  (cnt),
      .hit  (cnt_hit)
   );

   // Next state and switch direction; hs_req is only looked at in the run states.
   always_comb begin
      state_d  = state_q;
      dir_hs_d = dir_hs_q;
      cnt_term = SW_LAST;
      case (state_q)
         ST_LS_RUN: begin
            if (sleep_now) begin
               state_d = ST_SLEEP;
            end else if (bus.hs_req && !hs_block_q) begin
               state_d  = ST_HS_OSC;
               dir_hs_d = 1'b1;
            end
         end
         ST_HS_OSC: begin
            cnt_term = TMO_LAST;
            if ((cnt >= WAIT_LAST) && bus.hosc_rdy) begin
               state_d = ST_SW_GATE;
            end else if (cnt_hit) begin
               state_d = ST_LS_RUN;
            end
         end
         ST_SW_GATE: begin
            if (cnt_hit) begin
               state_d = ST_SW_SEL;
            end
         end
         ST_SW_SEL: begin
            if (cnt_hit) begin
               state_d = dir_hs_q ? ST_HS_RUN : ST_LS_RUN;
            end
         end
         ST_HS_RUN: begin
            if (!bus.hs_req || sleep_now) begin
               state_d  = ST_SW_GATE;
               dir_hs_d = 1'b0;
            end
         end
         ST_SLEEP: begin
            if (bus.wake) begin
               state_d = ST_LS_RUN;
            end
         end
         default: begin
            state_d = ST_LS_RUN;
         end
      endcase
   end

   // Sticky flags: pending sleep request and the post-timeout speed-up block.
   always_comb begin
      sleep_pend_d = sleep_pend_q;
      hs_block_d   = hs_block_q;
      if (state_q != ST_SLEEP) begin
         if (state_d == ST_SLEEP) begin
            sleep_pend_d = 1'b0;
         end else if (bus.sleep_req) begin
            sleep_pend_d = 1'b1;
         end
      end
      if ((state_q == ST_HS_OSC) && (state_d == ST_LS_RUN)) begin
         hs_block_d = 1'b1;
      end else if (((state_q == ST_LS_RUN) || (state_q == ST_HS_RUN)) && !bus.hs_req) begin
         hs_block_d = 1'b0;
      end
   end

   // Registered outputs derived from the state being entered; clk_sel only moves
   // when the gate phase hands over to the select phase.
   always_comb begin
      hosc_en_d  = (state_d == ST_HS_OSC) || (state_d == ST_SW_GATE) ||
                   (state_d == ST_SW_SEL) || (state_d == ST_HS_RUN);
      run_ctrl_d = (state_d == ST_LS_RUN) || (state_d == ST_HS_OSC) ||
                   (state_d == ST_HS_RUN);
      mode_d     = state_mode(state_d);
      busy_d     = (mode_d == MODE_TRANS);
      sw_done_d  = (state_q == ST_SW_SEL) && (state_d != ST_SW_SEL);
      osc_err_d  = (state_q == ST_HS_OSC) && (state_d == ST_LS_RUN);
      clk_sel_d  = clk_sel_q;
      if ((state_q == ST_SW_GATE) && (state_d == ST_SW_SEL)) begin
         clk_sel_d = dir_hs_q;
      end
      if (state_d == ST_SLEEP) begin
         clk_sel_d = 1'b0;
      end
   end

   // State, flag and output registers with synchronous reset to low-speed run.
   always_ff @(posedge lclk) begin
      if (rst) begin
         state_q      <= ST_LS_RUN;
         dir_hs_q     <= 1'b0;
         sleep_pend_q <= 1'b0;
         hs_block_q   <= 1'b0;
         hosc_en_q    <= 1'b0;
         clk_sel_q    <= 1'b0;
         run_ctrl_q   <= 1'b1;
         mode_q       <= MODE_LS;
         busy_q       <= 1'b0;
         sw_done_q    <= 1'b0;
         osc_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         dir_hs_q     <= dir_hs_d;
         sleep_pend_q <= sleep_pend_d;
         hs_block_q   <= hs_block_d;
         hosc_en_q    <= hosc_en_d;
         clk_sel_q    <= clk_sel_d;
         run_ctrl_q   <= run_ctrl_d;
         mode_q       <= mode_d;
         busy_q       <= busy_d;
         sw_done_q    <= sw_done_d;
         osc_err_q    <= osc_err_d;
      end
   end

   assign bus.hosc_en  = hosc_en_q;
   assign bus.clk_sel  = clk_sel_q;
   assign bus.run_ctrl = run_ctrl_q;
   assign bus.mode     = mode_q;
   assign bus.busy     = busy_q;
   assign bus.sw_done  = sw_done_q;
   assign bus.osc_err  = osc_err_q;

endmodule

// File: tb/tb_rcc_seq.sv
// Bench for rcc_seq: expected outputs come from the documented cycle timelines
// of each operation (speed-up, timeout, slow-down, sleep/wake, reset).
module tb_rcc_seq;

   localparam int OW = 64;
   localparam int OT = 1024;
   localparam int SW = 4;

   localparam logic [1:0] M_LS = 2'b00;
   localparam logic [1:0] M_HS = 2'b01;
   localparam logic [1:0] M_SL = 2'b10;
   localparam logic [1:0] M_TR = 2'b11;

   logic lclk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   rcc_seq_if bus ();

   rcc_seq #(
      .OSC_WAIT (OW),
      .OSC_TMO  (OT),
      .SW_WAIT  (SW)
   ) dut (
      .lclk (lclk),
      .rst  (rst),
      .bus  (bus)
   );

   always #5 lclk = ~lclk;

   // Output vector: {hosc_en, clk_sel, run_ctrl, mode, busy, sw_done, osc_err}.
   function automatic logic [7:0] vec(input logic h, input logic c, input logic r,
                                      input logic [1:0] m, input logic d, input logic e);
      return {h, c, r, m, (m == M_TR), d, e};
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic applyStimulus(input logic req, input logic slp, input logic wk,
                                input logic rdy, input logic rs);
      bus.hs_req    = req;
      bus.sleep_req = slp;
      bus.wake      = wk;
      bus.hosc_rdy  = rdy;
      rst           = rs;
   endtask

   task automatic tick();
      @(posedge lclk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input int n, input logic [7:0] exp);
      logic [7:0] obs;
      obs = {bus.hosc_en, bus.clk_sel, bus.run_ctrl, bus.mode, bus.busy, bus.sw_done, bus.osc_err};
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s edge=%0d observed=%b expected=%b", tag, n, obs, exp);
      end
   endtask

   // Idle in low-speed run; req=1 only while speed-up is blocked.
   task automatic runLs(input int cycles, input logic req);
      for (int i = 0; i < cycles; i++) begin
         applyStimulus(req, 1'b0, rbit(), rbit(), 1'b0);
         tick();
         checkOutput("ls_idle", i, vec(1'b0, 1'b0, 1'b1, M_LS, 1'b0, 1'b0));
      end
   endtask

   task automatic hsHold(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         applyStimulus(1'b1, 1'b0, rbit(), rbit(), 1'b0);
         tick();
         checkOutput("hs_hold", i, vec(1'b1, 1'b1, 1'b1, M_HS, 1'b0, 1'b0));
      end
   endtask

   // Speed-up from LS_RUN; hosc_rdy is first seen at edge r (r > OT never seen).
   task automatic speedUp(input int r, input bit toggle, input int sleep_at, input int abort_at);
      int         s, h, last;
      bit         tmo;
      logic [7:0] e;
      string      tag;
      logic       req;
      tmo  = (r > OT);
      s    = (r > OW) ? r : OW;
      h    = s + 2 * SW;
      last = tmo ? OT : h;
      if (abort_at >= 0) last = abort_at;
      tag  = tmo ? "timeout" : "speedup";
      for (int n = 0; n <= last; n++) begin
         req = (n == 0 || !toggle || n > h) ? 1'b1 : rbit();
         applyStimulus(req, (n == sleep_at), 1'b0, (n >= r), 1'b0);
         tick();
         if (tmo) begin
            e = (n < OT) ? vec(1'b1, 1'b0, 1'b1, M_TR, 1'b0, 1'b0)
                         : vec(1'b0, 1'b0, 1'b1, M_LS, 1'b0, 1'b1);
         end else begin
            e = vec(1'b1, (n >= s + SW), !((n >= s) && (n < h)),
                    (n >= h) ? M_HS : M_TR, (n == h), 1'b0);
         end
         checkOutput(tag, n, e);
      end
   endtask

   // HS->LS switch starting from HS_RUN; optionally continues into SLEEP.
   task automatic slowDown(input bit drop_req, input bit pulse_sleep, input bit to_sleep);
      logic [7:0] e;
      for (int n = 0; n <= 2 * SW; n++) begin
         applyStimulus((n == 0) ? !drop_req : rbit(), (n == 0) && pulse_sleep, 1'b0, rbit(), 1'b0);
         tick();
         if (n < SW)          e = vec(1'b1, 1'b1, 1'b0, M_TR, 1'b0, 1'b0);
         else if (n < 2 * SW) e = vec(1'b1, 1'b0, 1'b0, M_TR, 1'b0, 1'b0);
         else                 e = vec(1'b0, 1'b0, 1'b1, M_LS, 1'b1, 1'b0);
         checkOutput("slowdown", n, e);
      end
      if (to_sleep) begin
         applyStimulus(rbit(), 1'b0, 1'b0, rbit(), 1'b0);
         tick();
         checkOutput("pend_sleep", 0, vec(1'b0, 1'b0, 1'b0, M_SL, 1'b0, 1'b0));
      end
   endtask

   // Stay asleep (a stray sleep_req must not re-arm), then wake for one edge.
   task automatic sleepStay(input int cycles, input logic req_at_wake);
      for (int i = 0; i < cycles; i++) begin
         applyStimulus(rbit(), (i == cycles / 2), 1'b0, rbit(), 1'b0);
         tick();
         checkOutput("sleep", i, vec(1'b0, 1'b0, 1'b0, M_SL, 1'b0, 1'b0));
      end
      applyStimulus(req_at_wake, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("wake", 0, vec(1'b0, 1'b0, 1'b1, M_LS, 1'b0, 1'b0));
   endtask

   // Directed sequence of scenarios with randomized timing inside each.
   initial begin
      int r;
      int s;
      $display("[TB] reset");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("reset", 0, vec(1'b0, 1'b0, 1'b1, M_LS, 1'b0, 1'b0));
      tick();
      checkOutput("reset", 1, vec(1'b0, 1'b0, 1'b1, M_LS, 1'b0, 1'b0));
      runLs(10, 1'b0);

      $display("[TB] speed-up with oscillator already ready");
      speedUp(0, 1'b0, -1, -1);
      hsHold(5);
      slowDown(1'b1, 1'b0, 1'b0);
      runLs(3, 1'b0);

      $display("[TB] randomized speed-ups with hs_req toggling mid-transition");
      for (int k = 0; k < 4; k++) begin
         speedUp(int'($urandom_range(0, 200)), 1'b1, -1, -1);
         hsHold(int'($urandom_range(1, 6)));
         slowDown(1'b1, 1'b0, 1'b0);
         runLs(2, 1'b0);
      end

      $display("[TB] ready on the timeout edge, then timeout");
      speedUp(OT, 1'b1, -1, -1);
      slowDown(1'b1, 1'b0, 1'b0);
      runLs(2, 1'b0);
      speedUp(OT + 1, 1'b1, -1, -1);
      runLs(20, 1'b1);
      runLs(1, 1'b0);
      speedUp(int'($urandom_range(0, 100)), 1'b0, -1, -1);
      slowDown(1'b1, 1'b0, 1'b0);
      runLs(2, 1'b0);

      $display("[TB] sleep requested during the gate phase");
      r = int'($urandom_range(0, 100));
      s = (r > OW) ? r : OW;
      speedUp(r, 1'b1, s + int'($urandom_range(1, SW)), -1);
      slowDown(1'b0, 1'b0, 1'b1);
      sleepStay(int'($urandom_range(3, 8)), 1'b1);
      speedUp(0, 1'b0, -1, -1);
      hsHold(2);
      slowDown(1'b0, 1'b1, 1'b1);
      sleepStay(4, 1'b0);
      runLs(3, 1'b0);

      $display("[TB] sleep beats hs_req in LS_RUN");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("ls_sleep", 0, vec(1'b0, 1'b0, 1'b0, M_SL, 1'b0, 1'b0));
      sleepStay(3, 1'b0);
      runLs(2, 1'b0);

      $display("[TB] reset two cycles into the select phase");
      speedUp(0, 1'b1, -1, OW + SW + 2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("mid_reset", 0, vec(1'b0, 1'b0, 1'b1, M_LS, 1'b0, 1'b0));
      runLs(3, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rcc_seq.md
# rcc_seq

Clock-mode sequencer for the reset/clock controller. It owns the `clk_sel`, `run_ctrl` and high-speed oscillator enable that drive the glitch-free lclk/hclk switch and the runclk gate. It sequences low→high and high→low speed changes (oscillator start, settle, gated switch) and sleep/wake. It runs on the always-on `lclk` domain, so it never depends on the clock it is switching.

## Interface
- `OSC_WAIT`, 64: minimum `lclk` cycles from `hosc_en` rising to switch start.
- `OSC_TMO`, 1024: oscillator-ready timeout in cycles. Must satisfy `OSC_TMO > OSC_WAIT`.
- `SW_WAIT`, 4: cycles spent in each of the gate phase and the select phase. Must be ≥1.

Ports:
- `lclk`  in  1: always-on low-speed clock; the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `hs_req`  in  1: level; 1 requests hclk operation.
- `sleep_req`  in  1: single-cycle pulse requesting sleep.
- `wake`  in  1: level; exits sleep.
- `hosc_rdy`  in  1: high-speed oscillator ready, already synchronised to `lclk`.
- `hosc_en`  out  1: high-speed oscillator enable.
- `clk_sel`  out  1: clock-switch select; 0 = lclk, 1 = hclk.
- `run_ctrl`  out  1: 1 lets runclk toggle; 0 holds it high.
- `mode`  out  2: 00 LS, 01 HS, 10 SLEEP, 11 transitioning.
- `busy`  out  1: high in any non-RUN, non-SLEEP state.
- `sw_done`  out  1: one-cycle pulse on arrival in LS_RUN or HS_RUN after a switch.
- `osc_err`  out  1: one-cycle pulse on oscillator timeout.

## Operation
- **States:** LS_RUN, HS_OSC, SW_GATE, SW_SEL, HS_RUN, SLEEP. A direction register `dir_hs` records the target of a switch.
- **Counter:** `cnt` clears on every state entry and increments once per cycle in the state. Its width is clog2(`OSC_TMO`+1). It saturates and never wraps.
- **LS_RUN, sleep:** if a sleep is pending (`sleep_req` this cycle or latched), go to SLEEP. Sleep takes priority over `hs_req`.
- **LS_RUN, speed-up:** else if `hs_req`=1 and `hs_block`=0, go to HS_OSC with `dir_hs`=1.
- **HS_OSC:** `hosc_en`=1 and `run_ctrl` stays 1, so the CPU keeps running on lclk.
  - If `cnt`≥`OSC_WAIT`-1 and `hosc_rdy`=1, go to SW_GATE.
  - Else if `cnt`=`OSC_TMO`-1, go to LS_RUN, drop `hosc_en`, pulse `osc_err` and set `hs_block`.
  - If ready and timeout occur in the same cycle, success wins.
- **SW_GATE:** `run_ctrl`=0. After `SW_WAIT` cycles, go to SW_SEL; on that transition `clk_sel` takes `dir_hs`.
- **SW_SEL:** `run_ctrl`=0. After `SW_WAIT` cycles:
  - `dir_hs`=1: go to HS_RUN.
  - `dir_hs`=0: go to LS_RUN and clear `hosc_en`.
  - Either way, set `run_ctrl`=1 and pulse `sw_done`.
- **HS_RUN:** if `hs_req`=0 or a sleep is pending, go to SW_GATE with `dir_hs`=0.
- **Pending sleep:** once back in LS_RUN, a pending sleep proceeds to SLEEP on the next cycle.
- **SLEEP:** `run_ctrl`=0, `hosc_en`=0, `clk_sel`=0. When `wake`=1, go to LS_RUN with `run_ctrl`=1. If `hs_req` is still 1, a normal speed-up follows.
- **Sampling rules:**
  - `hs_req` is sampled only in LS_RUN and HS_RUN; changes during a transition are ignored.
  - A `sleep_req` pulse arriving in any non-SLEEP state sets `sleep_pend`. `sleep_pend` clears on entry to SLEEP.
  - `wake` outside SLEEP is ignored.
- **`hs_block`:** clears when `hs_req`=0 is sampled.
- **Reset:** `rst` in any state returns to LS_RUN on the next edge, abandoning any switch in progress.
  - Outputs after reset: `hosc_en`=0, `clk_sel`=0, `run_ctrl`=1, `mode`=00, `busy`=0, `sw_done`=0, `osc_err`=0.
  - Internal flags after reset: `sleep_pend`=0, `hs_block`=0, `dir_hs`=0, `cnt`=0.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Speed-up, with `hs_req` sampled at edge 0 and `hosc_rdy` already high:
  - `hosc_en`=1 after edge 0.
  - `run_ctrl`=0 after edge `OSC_WAIT`.
  - `clk_sel`=1 after edge `OSC_WAIT`+`SW_WAIT`.
  - `run_ctrl`=1 and `sw_done`=1 after edge `OSC_WAIT`+2·`SW_WAIT`.
  - Defaults: 64 / 68 / 72.
- Slow-down, with `hs_req`=0 sampled at edge 0:
  - `run_ctrl`=0 after edge 0.
  - `clk_sel`=0 after edge `SW_WAIT`.
  - `run_ctrl`=1 and `hosc_en`=0 after edge 2·`SW_WAIT`.
- `clk_sel` changes only while `run_ctrl` has been 0 for exactly `SW_WAIT` cycles.
- Sleep from LS_RUN takes 1 cycle. Wake takes 1 cycle.
- Timeout: `osc_err` is pulsed after edge `OSC_TMO`, counted from the edge that sampled `hs_req`.

## Structure
- Package `rcc_pkg` holds:
  - the state enum;
  - `mode` encodings: MODE_LS, MODE_HS, MODE_SLEEP, MODE_TRANS;
  - default parameter constants.
- One sub-module, `rcc_dly_cnt`: clear-on-load saturating counter with a terminal-compare output. It is instantiated once and shared by all states.
- The top level holds the FSM, `sleep_pend`, `hs_block`, `dir_hs` and the output registers.

## Test plan
- **Reset:** reset, then idle 10 cycles → `run_ctrl`=1, `clk_sel`=0, `hosc_en`=0, `mode`=00 throughout.
- **Speed-up:** `hs_req`=1 with `hosc_rdy`=1 → `run_ctrl` falls at +64, `clk_sel` rises at +68, `run_ctrl` rises with `sw_done` at +72, then `mode`=01.
- **Oscillator timeout:** `hs_req`=1 with `hosc_rdy`=0 → `osc_err` at +1024, back to LS with `hosc_en`=0.
  - No retry until `hs_req` drops for 1 cycle and rises again.
- **Sleep during speed-up:** `sleep_req` pulse during SW_GATE → speed-up completes to HS_RUN, then HS→LS switch, then SLEEP.
  - In SLEEP: `run_ctrl`=0, `clk_sel`=0, `hosc_en`=0.
  - `wake`=1 → `run_ctrl`=1 next cycle.
- **Mid-switch reset:** assert `rst` 2 cycles into SW_SEL → next edge shows reset values, with no `sw_done` or `osc_err` pulse.
- **Ignored changes during transition:** toggle `hs_req` 1→0→1 during HS_OSC → switch completes to HS, `mode`=01.
  - Then `hs_req`=0 → `clk_sel` falls `SW_WAIT` cycles after the sampling edge.
